uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmit stage that produces the line consumed by `uart_receiver`. Accepts bytes over a valid/ready handshake into a small FIFO, then serialises each as a start bit, 8 data bits MSB first, an optional even-parity bit and `STOP_BITS` stop bits. Every bit is held for `BAUD_RATE` clock cycles. This matches the receiver's frame format and bit period, so the two blocks connect back-to-back.

## Interface
- `BAUD_RATE`, 16: clock cycles per serial bit; legal values ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two ≥ 2.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1  producer offers `tx_data`.
- `tx_ready`  out  1  FIFO not full; registered.
- `tx_line`  out  1  serial output; idles high; registered.
- `tx_busy`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- Reset values: `tx_line`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1; FIFO empty, FSM in IDLE, baud and bit counters cleared.
- Push: `tx_valid && tx_ready` writes `tx_data` at the FIFO tail. A push while `tx_ready`=0 is ignored; no data is lost or overwritten.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. Otherwise `tx_line`=1.
  - START: `tx_line`=0 for `BAUD_RATE` cycles, then DATA.
  - DATA: drive bit 7 down to bit 0, `BAUD_RATE` cycles each. After bit 0, go to PARITY if compiled in, else STOP.
  - PARITY: drive the XOR of the 8 data bits for `BAUD_RATE` cycles, then STOP.
  - STOP: `tx_line`=1 for `STOP_BITS`×`BAUD_RATE` cycles.
    - On the final cycle, if the FIFO is non-empty, pop and go directly to START, leaving zero idle cycles between frames.
    - Otherwise go to IDLE.
- Baud counter: counts 0..`BAUD_RATE`-1 and wraps; width is clog2(`BAUD_RATE`). Bit counter: 0..7.
- `tx_busy`: 1 from the first START cycle through the last STOP cycle. It stays 1 continuously across back-to-back frames.
- `tx_done`: 1 for exactly the last clock cycle of the last stop bit of each frame.
- Simultaneous push and pop: the FIFO count is unchanged and both operations take effect. `tx_ready` is computed from the registered count, so a pop does not free a slot for a push in the same cycle.
- Reset mid-frame: the frame is abandoned, `tx_line` returns to 1 asynchronously and the FIFO is flushed. After release, nothing is transmitted until a new push.

## Timing
- Latency: a push accepted at edge N into an empty FIFO while IDLE makes the FIFO non-empty after edge N. The FSM pops at edge N+1, so `tx_line` falls after edge N+1.
- Frame length: (1 + 8 + P + `STOP_BITS`) × `BAUD_RATE` cycles, where P is 1 with parity and 0 without.
- Default frame: 160 cycles without parity, 176 with.
- All outputs are registered. `tx_line` changes only on baud-counter wrap boundaries or on reset.

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state inserts one even-parity bit after the data bits.
- `UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent, and DATA goes straight to STOP.

## Test plan
- Reset: hold `rst`=1 for 3 cycles. Required while held and on release: `tx_line`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0.
- Single byte 0xA5, no parity, `BAUD_RATE`=16:
  - start bit 0 for 16 cycles;
  - data bits 1,0,1,0,0,1,0,1 for 16 cycles each;
  - stop bit 1 for 16 cycles;
  - `tx_done` high only on cycle 160 of the frame; `tx_busy` high for exactly 160 cycles.
- Back-to-back 0x00 then 0xFF: the second start bit begins on the cycle immediately after the first frame's last stop cycle. `tx_busy` never drops and `tx_done` pulses twice.
- FIFO full, `FIFO_DEPTH`=4:
  - hold `tx_valid`=1 with bytes 0x10..0x15;
  - exactly 5 are accepted before `tx_ready`=0;
  - 0x15 is accepted only after the first frame ends;
  - all 6 bytes appear on the line in order.
- Reset mid-frame: assert `rst` during data bit 3 of 0x3C with 2 bytes queued. `tx_line` goes to 1 immediately and `tx_ready`=1; after release the line stays idle for 200 cycles.
- Parity with `UART_TX_PARITY_EN` defined: 0x07 gives parity bit 1 and 0xA5 gives parity bit 0. Each frame is 176 cycles long.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit stage: byte FIFO feeding a start / 8 data (MSB first) / [parity] / stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_transmitter #(
  parameter int BAUD_RATE  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BW = (BAUD_RATE > 1) ? $clog2(BAUD_RATE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_RATE - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_RATE - 2);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
`ifdef UART_TX_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  // FIFO
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic        r_ready;
  logic        w_push, w_pop, w_empty;
  logic [AW:0] w_cnt_nxt;

  assign w_push    = tx_valid & r_ready;
  assign w_empty   = (r_cnt == '0);
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= tx_data;
  end

  // Ready looks at the registered count, so a pop never frees a slot in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != CNT_FULL);
    end
  end

  // Serialiser
  state_t        r_state, w_state;
  logic [BW-1:0] r_baud, w_baud;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          r_line, w_line, r_busy, w_busy, r_done, w_done;
  logic          w_wrap;
`ifdef UART_TX_PARITY_EN
  logic          r_par, w_par;
`endif

  assign w_wrap = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_line  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_baud  <= w_baud;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_line  <= w_line;
      r_busy  <= w_busy;
      r_done  <= w_done;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  // Outputs are computed for the next cycle and registered, so tx_line moves only on baud wraps.
  always_comb begin
    w_state = r_state;
    w_baud  = r_baud;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_line  = 1'b1;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par   = r_par;
`endif
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_shift = r_mem[r_rd];
`ifdef UART_TX_PARITY_EN
          w_par   = ^r_mem[r_rd];
`endif
          w_state = ST_START;
          w_baud  = '0;
          w_line  = 1'b0;
          w_busy  = 1'b1;
        end
      end
      ST_START: begin
        w_line = 1'b0;
        w_baud = r_baud + 1'b1;
        if (w_wrap) begin
          w_baud  = '0;
          w_bit   = '0;
          w_state = ST_DATA;
          w_line  = r_shift[7];
        end
      end
      ST_DATA: begin
        w_line = r_shift[7];
        w_baud = r_baud + 1'b1;
        if (w_wrap) begin
          w_baud = '0;
          if (r_bit == 3'd7) begin
            w_bit   = '0;
`ifdef UART_TX_PARITY_EN
            w_state = ST_PARITY;
            w_line  = r_par;
`else
            w_state = ST_STOP;
            w_line  = 1'b1;
`endif
          end else begin
            w_bit   = r_bit + 1'b1;
            w_shift = {r_shift[6:0], 1'b0};
            w_line  = r_shift[6];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        w_line = r_par;
        w_baud = r_baud + 1'b1;
        if (w_wrap) begin
          w_baud  = '0;
          w_bit   = '0;
          w_state = ST_STOP;
          w_line  = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        w_line = 1'b1;
        w_baud = r_baud + 1'b1;
        if ((r_baud == BAUD_PRE) && (r_bit == STOP_LAST)) w_done = 1'b1;
        if (w_wrap) begin
          w_baud = '0;
          if (r_bit == STOP_LAST) begin
            w_bit = '0;
            if (!w_empty) begin
              w_pop   = 1'b1;
              w_shift = r_mem[r_rd];
`ifdef UART_TX_PARITY_EN
              w_par   = ^r_mem[r_rd];
`endif
              w_state = ST_START;
              w_line  = 1'b0;
            end else begin
              w_state = ST_IDLE;
              w_busy  = 1'b0;
            end
          end else begin
            w_bit = r_bit + 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign tx_ready = r_ready;
  assign tx_line  = r_line;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: expected line/busy/done waveforms are built per byte from the frame format.
module tb_uart_transmitter;
  localparam int BAUD  = 16;
  localparam int DEPTH = 4;
  localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int FRAME = (9 + PBIT + STOPB) * BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_line, tx_busy, tx_done;

  int n_chk = 0;
  int n_fail = 0;

  logic       exp_line[$], exp_busy[$], exp_done[$];
  logic       obs_line[$];
  logic [7:0] bq[$];

  uart_transmitter #(.BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(STOPB)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference waveform: each symbol is a line level held for BAUD cycles.
  task automatic add_frame(input logic [7:0] b);
    logic sym[$];
    sym.push_back(1'b0);
    for (int i = 7; i >= 0; i--) sym.push_back(b[i]);
    if (PBIT == 1) sym.push_back(^b);
    for (int s = 0; s < STOPB; s++) sym.push_back(1'b1);
    for (int k = 0; k < sym.size(); k++)
      for (int c = 0; c < BAUD; c++) begin
        exp_line.push_back(sym[k]);
        exp_busy.push_back(1'b1);
        exp_done.push_back((k == sym.size() - 1) && (c == BAUD - 1));
      end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_line.push_back(1'b1);
      exp_busy.push_back(1'b0);
      exp_done.push_back(1'b0);
    end
  endtask

  // Called on the negedge of the first expected cycle.
  task automatic check_stream(input string name);
    obs_line.delete();
    for (int i = 0; i < exp_line.size(); i++) begin
      if (i > 0) @(negedge clk);
      obs_line.push_back(tx_line);
      n_chk += 3;
      if (tx_line !== exp_line[i]) begin
        n_fail++;
        $display("FAIL %s tx_line cycle %0d: got %b expected %b", name, i + 1, tx_line, exp_line[i]);
      end
      if (tx_busy !== exp_busy[i]) begin
        n_fail++;
        $display("FAIL %s tx_busy cycle %0d: got %b expected %b", name, i + 1, tx_busy, exp_busy[i]);
      end
      if (tx_done !== exp_done[i]) begin
        n_fail++;
        $display("FAIL %s tx_done cycle %0d: got %b expected %b", name, i + 1, tx_done, exp_done[i]);
      end
    end
    exp_line.delete(); exp_busy.delete(); exp_done.delete();
  endtask

  // Push bq on consecutive cycles while checking the resulting stream.
  task automatic run_burst(input string name);
    foreach (bq[i]) add_frame(bq[i]);
    add_idle(3);
    fork
      begin
        foreach (bq[i]) begin
          @(negedge clk);
          n_chk++;
          if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s tx_ready before push %0d: got %b expected 1", name, i, tx_ready);
          end
          tx_valid = 1'b1;
          tx_data  = bq[i];
        end
        @(negedge clk);
        tx_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (tx_line !== 1'b1 || tx_busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s latency: line=%b busy=%b one cycle after push, expected 1/0", name, tx_line, tx_busy);
        end
        @(negedge clk);
        check_stream(name);
      end
    join
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({tx_line, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
        n_fail++;
        $display("FAIL reset_hold {line,ready,busy,done}: got %b expected 1100", {tx_line, tx_ready, tx_busy, tx_done});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({tx_line, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_release {line,ready,busy,done}: got %b expected 1100", {tx_line, tx_ready, tx_busy, tx_done});
    end
  endtask

  task automatic test_single();
    bq.delete(); bq.push_back(8'hA5);
    run_burst("single_a5");
  endtask

  task automatic test_back_to_back();
    bq.delete(); bq.push_back(8'h00); bq.push_back(8'hFF);
    run_burst("back_to_back");
  endtask

  task automatic test_fifo_full();
    int idx = 0;
    int cyc = -1;
    int first_full = -1;
    int acc15 = -1;
    for (int i = 0; i < 6; i++) add_frame(8'(8'h10 + i));
    add_idle(3);
    fork
      begin
        bit acc;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h10;
        while (idx < 6 && cyc < 400) begin
          acc = tx_ready;
          if (!tx_ready && first_full < 0) first_full = idx;
          if (acc && idx == 5) acc15 = cyc;
          @(negedge clk);
          cyc++;
          if (acc) begin
            idx++;
            if (idx < 6) tx_data = 8'(8'h10 + idx);
            else tx_valid = 1'b0;
          end
        end
        tx_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        check_stream("fifo_full");
      end
    join
    n_chk += 3;
    if (first_full !== 5) begin
      n_fail++;
      $display("FAIL fifo_full accepted_before_full: got %0d expected 5", first_full);
    end
    if (acc15 !== FRAME + 1) begin
      n_fail++;
      $display("FAIL fifo_full 0x15_accept_cycle: got %0d expected %0d", acc15, FRAME + 1);
    end
    if (idx !== 6) begin
      n_fail++;
      $display("FAIL fifo_full bytes_accepted: got %0d expected 6", idx);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge clk); tx_data = 8'h11;
    @(negedge clk); tx_data = 8'h22;          // frame cycle 1
    @(negedge clk); tx_valid = 1'b0;          // frame cycle 2
    repeat (86) @(negedge clk);               // frame cycle 88: data bit 3 of 0x3C
    n_chk++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre: line=%b busy=%b expected 1/1", tx_line, tx_busy);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({tx_line, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_mid async {line,ready,busy,done}: got %b expected 1100", {tx_line, tx_ready, tx_busy, tx_done});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_chk++;
      if (tx_line !== 1'b1 || tx_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid idle cycle %0d: line=%b busy=%b expected 1/0", c, tx_line, tx_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 4);
      bq.delete();
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
      run_burst("random");
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bq.delete(); bq.push_back(8'h07); bq.push_back(8'hA5);
    run_burst("parity");
    n_chk += 2;
    if (obs_line[151] !== 1'b1) begin
      n_fail++;
      $display("FAIL parity 0x07 parity_bit: got %b expected 1", obs_line[151]);
    end
    if (obs_line[FRAME + 151] !== 1'b0) begin
      n_fail++;
      $display("FAIL parity 0xA5 parity_bit: got %b expected 0", obs_line[FRAME + 151]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
